// File: rtl/otter_mem_pkg.sv
// Shared types for the line-fill / writeback memory responder.
//   LINE_WORDS       : default words per cache line
//   line_t           : one cache line, index 0 = lowest address
//   mem_resp_state_t : responder FSM states
package otter_mem_pkg;

  localparam int LINE_WORDS = 4;

  typedef logic [31:0] line_t [LINE_WORDS];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ_BURST,
    WRITE_BURST
  } mem_resp_state_t;

endpackage

// File: rtl/line_mem_array.sv
// Single-port word RAM, DEPTH x 32, synchronous write and registered read.
//   clk   : clock
//   en    : port enable (read when !we, write when we)
//   we    : write enable
//   addr  : word address
//   wdata : write word
//   rdata : read word, valid the cycle after an enabled read
module line_mem_array #(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // No reset on storage or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Slow backing-memory responder for cache line fills and writebacks.
// One request at a time; after LATENCY cycles a read line streams out one
// word per cycle, or a writeback line is committed one word per cycle.
//   CLK, RST              : clock, async active-high reset
//   REQ_VALID/REQ_READY   : request handshake (ready only when idle)
//   REQ_WE                : 1 = writeback, 0 = fill
//   REQ_ADDR              : byte address, in-line offset bits ignored
//   REQ_WDATA             : writeback line, index 0 = lowest address
//   RESP_VALID/DATA/IDX   : read beat, data forced to 0 when not valid
//   RESP_LAST             : final read beat
//   WR_DONE               : pulse on the final writeback beat
//   BUSY                  : request in progress
module line_mem_responder
  import otter_mem_pkg::*;
#(
  parameter int WORDS_PER_LINE = LINE_WORDS,
  parameter int DEPTH          = 16384,
  parameter int LATENCY        = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic                              REQ_WE,
  input  logic [31:0]                       REQ_ADDR,
  input  logic [31:0]                       REQ_WDATA [WORDS_PER_LINE],
  output logic                              RESP_VALID,
  output logic [31:0]                       RESP_DATA,
  output logic [$clog2(WORDS_PER_LINE)-1:0] RESP_IDX,
  output logic                              RESP_LAST,
  output logic                              WR_DONE,
  output logic                              BUSY
);

  localparam int IW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = IW + 2;
  localparam int AW  = $clog2(DEPTH);
  localparam int LAW = AW - IW;
  localparam int CW  = $clog2(LATENCY) + 1;

  localparam logic [31:0]   LINES     = 32'(DEPTH / WORDS_PER_LINE);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);
  localparam logic [IW-1:0] LAST_BEAT = IW'(WORDS_PER_LINE - 1);

  mem_resp_state_t state, state_d;

  logic [CW-1:0]  wait_cnt;
  logic [IW-1:0]  beat;
  logic [LAW-1:0] line;
  logic           is_write;
  logic           in_range;
  logic [31:0]    wdata_q [WORDS_PER_LINE];

  logic [31:0]    req_line;
  logic           req_in_range;
  logic           accept;
  logic           last;

  logic           ram_en;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [31:0]    ram_rdata;

  assign req_line     = REQ_ADDR >> OFF;
  assign req_in_range = req_line < LINES;
  assign accept       = REQ_VALID && (state == IDLE);
  assign last         = beat == LAST_BEAT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // The RAM read is registered, so the address presented in each cycle is
  // the word needed on RESP_DATA in the following cycle: word 0 while idle
  // or waiting, word beat+1 during a read burst.
  always_comb begin
    state_d    = state;
    REQ_READY  = 1'b0;
    BUSY       = 1'b1;
    RESP_VALID = 1'b0;
    RESP_LAST  = 1'b0;
    WR_DONE    = 1'b0;
    ram_en     = 1'b1;
    ram_we     = 1'b0;
    ram_addr   = {line, {IW{1'b0}}};
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        BUSY      = 1'b0;
        ram_addr  = {req_line[LAW-1:0], {IW{1'b0}}};
        if (REQ_VALID) begin
          if (LATENCY == 1) state_d = REQ_WE ? WRITE_BURST : READ_BURST;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= CW'(1)) state_d = is_write ? WRITE_BURST : READ_BURST;
      end
      READ_BURST: begin
        RESP_VALID = 1'b1;
        RESP_LAST  = last;
        ram_addr   = {line, beat + IW'(1)};
        if (last) state_d = IDLE;
      end
      WRITE_BURST: begin
        WR_DONE  = last;
        ram_en   = in_range;
        ram_we   = in_range;        // out-of-range writebacks are dropped
        ram_addr = {line, beat};
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
      beat     <= '0;
      line     <= '0;
      is_write <= 1'b0;
      in_range <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        line     <= req_line[LAW-1:0];
        is_write <= REQ_WE;
        in_range <= req_in_range;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      // Power-of-2 line length: the counter wraps to 0 on the last beat.
      beat <= (state == READ_BURST || state == WRITE_BURST) ? beat + IW'(1) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) wdata_q <= REQ_WDATA;
  end

  assign RESP_DATA = (RESP_VALID && in_range) ? ram_rdata : 32'h0;
  assign RESP_IDX  = RESP_VALID ? beat : '0;

  line_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q[beat]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  localparam int W     = 4;
  localparam int DEPTH = 16384;
  localparam int LAT   = 4;
  localparam int IW    = $clog2(W);
  localparam int OFF   = IW + 2;
  localparam int NC    = LAT + W + 1;
  localparam int LINES = DEPTH / W;
  // snapshot layout: {valid, last, wr_done, ready, busy, idx[1:0], data[31:0]}
  localparam logic [38:0] RDY = 39'h08_0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [31:0] REQ_ADDR = 32'h0;
  logic [31:0] REQ_WDATA [W];
  logic        REQ_READY, RESP_VALID, RESP_LAST, WR_DONE, BUSY;
  logic [31:0] RESP_DATA;
  logic [IW-1:0] RESP_IDX;

  int errors = 0;
  int checks = 0;

  logic [38:0] obs [NC];
  logic [31:0] model [int unsigned];
  int unsigned wl [$];

  line_mem_responder #(.WORDS_PER_LINE(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_IDX(RESP_IDX),
    .RESP_LAST(RESP_LAST), .WR_DONE(WR_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [38:0] snap();
    return {RESP_VALID, RESP_LAST, WR_DONE, REQ_READY, BUSY, RESP_IDX, RESP_DATA};
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] ln, int b);
    int unsigned wa;
    if (ln >= 32'(LINES)) return 32'h0;
    wa = int'(ln) * W + b;
    return model.exists(wa) ? model[wa] : 32'h0;
  endfunction

  // Expected snapshot in cycle k of a transaction accepted at the end of cycle 0.
  function automatic logic [38:0] exp_at(int k, logic we, logic [31:0] addr);
    logic [31:0] ln;
    int b;
    logic burst, busy, rv, fin;
    ln    = addr >> OFF;
    b     = k - LAT;
    burst = (b >= 0) && (b < W);
    busy  = (k >= 1) && (k < LAT + W);
    rv    = burst && !we;
    fin   = burst && (b == W - 1);
    return {rv, rv && fin, we && fin, !busy, busy,
            rv ? IW'(b) : IW'(0), rv ? mem_word(ln, b) : 32'h0};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [W-1:0][31:0] wd);
    logic [31:0] ln;
    ln = addr >> OFF;
    if (ln < 32'(LINES)) begin
      for (int i = 0; i < W; i++) model[int'(ln) * W + i] = wd[i];
      wl.push_back(ln);
    end
  endtask

  // Called at a falling edge; drives the request for cycle 0 and records
  // cycles 0..LAT+W. With hold set, REQ_VALID stays high with junk while busy.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [W-1:0][31:0] wd, input bit hold);
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    for (int i = 0; i < W; i++) REQ_WDATA[i] = wd[i];
    #1 obs[0] = snap();
    for (int k = 1; k < NC; k++) begin
      @(negedge CLK);
      obs[k]    = snap();
      REQ_VALID = hold && (k < NC - 1);
      REQ_WE    = 1'($urandom);
      REQ_ADDR  = $urandom;
      for (int i = 0; i < W; i++) REQ_WDATA[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    logic [38:0] s;
    for (int i = 0; i < W; i++) REQ_WDATA[i] = 32'h0;
    @(negedge CLK);
    s = snap();
    checks++;
    if (s !== RDY) begin errors++; $display("FAIL reset_held: got %h want %h", s, RDY); end
    RST = 1'b0;
    @(negedge CLK);
    s = snap();
    checks++;
    if (s !== RDY) begin errors++; $display("FAIL reset_released: got %h want %h", s, RDY); end
  endtask

  task automatic test_read_basic();
    logic st_we [2];
    logic [31:0] st_ad [2];
    logic [W-1:0][31:0] st_wd [2];
    st_we[0] = 1'b1; st_ad[0] = 32'h100; st_wd[0] = {32'h44, 32'h33, 32'h22, 32'h11};
    st_we[1] = 1'b0; st_ad[1] = 32'h100; st_wd[1] = '0;
    for (int t = 0; t < 2; t++) begin
      do_req(st_we[t], st_ad[t], st_wd[t], 1'b0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, st_we[t], st_ad[t]);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL read_basic s%0d c%0d: got %h want %h", t, k, obs[k], e); end
      end
      if (st_we[t]) model_write(st_ad[t], st_wd[t]);
    end
  endtask

  task automatic test_back_to_back();
    logic st_we [2];
    logic [31:0] st_ad [2];
    logic [W-1:0][31:0] st_wd [2];
    st_we[0] = 1'b1; st_ad[0] = 32'h200; st_wd[0] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    st_we[1] = 1'b0; st_ad[1] = 32'h200; st_wd[1] = '0;
    for (int t = 0; t < 2; t++) begin
      do_req(st_we[t], st_ad[t], st_wd[t], 1'b0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, st_we[t], st_ad[t]);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL back_to_back s%0d c%0d: got %h want %h", t, k, obs[k], e); end
      end
      if (st_we[t]) model_write(st_ad[t], st_wd[t]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] st_ad [2];
    st_ad[0] = 32'h20C;
    st_ad[1] = 32'h200;
    for (int t = 0; t < 2; t++) begin
      do_req(1'b0, st_ad[t], '0, 1'b0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, 1'b0, st_ad[t]);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL misaligned s%0d c%0d: got %h want %h", t, k, obs[k], e); end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic st_we [4];
    logic [31:0] st_ad [4];
    logic [W-1:0][31:0] st_wd [4];
    st_we[0] = 1'b1; st_ad[0] = 32'h0;     st_wd[0] = {$urandom, $urandom, $urandom, $urandom};
    st_we[1] = 1'b1; st_ad[1] = 32'h10000; st_wd[1] = {4{32'hDEADBEEF}};
    st_we[2] = 1'b0; st_ad[2] = 32'h10000; st_wd[2] = '0;
    st_we[3] = 1'b0; st_ad[3] = 32'h0;     st_wd[3] = '0;
    for (int t = 0; t < 4; t++) begin
      do_req(st_we[t], st_ad[t], st_wd[t], 1'b0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, st_we[t], st_ad[t]);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL out_of_range s%0d c%0d: got %h want %h", t, k, obs[k], e); end
      end
      if (st_we[t]) model_write(st_ad[t], st_wd[t]);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] st_ad [2];
    st_ad[0] = 32'h100;
    st_ad[1] = 32'h200;
    for (int t = 0; t < 2; t++) begin
      do_req(1'b0, st_ad[t], '0, t == 0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, 1'b0, st_ad[t]);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL busy_ignore s%0d c%0d: got %h want %h", t, k, obs[k], e); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [W-1:0][31:0] wd;
    logic [38:0] s;
    logic seen;
    do_req(1'b1, 32'h300, '0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      logic [38:0] e;
      e = exp_at(k, 1'b1, 32'h300);
      checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL rst_pre c%0d: got %h want %h", k, obs[k], e); end
    end
    model_write(32'h300, '0);
    wd = {32'd4, 32'd3, 32'd2, 32'd1};
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 32'h300;
    for (int i = 0; i < W; i++) REQ_WDATA[i] = wd[i];
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      seen = seen | WR_DONE;
      REQ_VALID = 1'b0;
    end
    @(negedge CLK);
    RST = 1'b1;
    #1 s = snap();
    checks++;
    if (s !== RDY) begin errors++; $display("FAIL rst_mid_outputs: got %h want %h", s, RDY); end
    @(negedge CLK);
    seen = seen | WR_DONE;
    RST = 1'b0;
    @(negedge CLK);
    seen = seen | WR_DONE;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_wr_done: got %b want 0", seen); end
    model[32'h0C0] = 32'd1;   // only beat 0 was committed before the reset
    do_req(1'b0, 32'h300, '0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      logic [38:0] e;
      e = exp_at(k, 1'b0, 32'h300);
      checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL rst_readback c%0d: got %h want %h", k, obs[k], e); end
    end
  endtask

  task automatic test_random();
    logic we;
    logic [31:0] ad;
    logic [W-1:0][31:0] wd;
    int r;
    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        we = 1'($urandom);
        ad = $urandom_range(32'hFFFF_FFFF, 32'h0001_0000);
      end else if (r < 6 || wl.size() == 0) begin
        we = 1'b1;
        ad = ($urandom_range(0, 63) << OFF) | $urandom_range(0, 15);
      end else begin
        we = 1'b0;
        ad = (wl[$urandom_range(0, wl.size() - 1)] << OFF) | $urandom_range(0, 15);
      end
      for (int i = 0; i < W; i++) wd[i] = $urandom;
      do_req(we, ad, wd, 1'b0);
      for (int k = 0; k < NC; k++) begin
        logic [38:0] e;
        e = exp_at(k, we, ad);
        checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL random t%0d we=%0b a=%h c%0d: got %h want %h", t, we, ad, k, obs[k], e); end
      end
      if (we) model_write(ad, wd);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_misaligned();
    test_out_of_range();
    test_busy_ignore();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Backing-memory responder on the line-fill/writeback interface used by the I- and D-cache controllers (CacheFSM initiators).
- Accepts one line request at a time: a read-line (fill) or a write-line (writeback).
- After a fixed access latency it streams a read line out one word per cycle, or commits a writeback line one word per cycle.
- Models slow main memory beneath DM_Cache/SA_Cache and replaces the zero-latency imem/dmem line models.

Parameters:
WORDS_PER_LINE, 4, words per cache line; power of 2, ≥2
DEPTH, 16384, memory size in 32-bit words (64 KiB)
LATENCY, 4, cycles from acceptance to first beat; ≥1

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  reset
REQ_VALID  in  1  request present
REQ_READY  out  1  responder idle, can accept
REQ_WE  in  1  1 = writeback line, 0 = fill (read) line
REQ_ADDR  in  32  byte address; low log2(WORDS_PER_LINE)+2 bits ignored
REQ_WDATA  in  32 x WORDS_PER_LINE  writeback line, unpacked array; index 0 = lowest address
RESP_VALID  out  1  read beat valid
RESP_DATA  out  32  read beat word
RESP_IDX  out  log2(WORDS_PER_LINE)  word index of the current beat
RESP_LAST  out  1  final read beat
WR_DONE  out  1  one-cycle pulse, writeback complete
BUSY  out  1  request in progress

Interface (already decided):
- One clock, CLK.
- RST is asynchronous and active-high.

Behaviour:
Reset:
- State returns to IDLE. REQ_READY=1; all other outputs 0; counters 0.
- Memory contents are not reset.
- Reset mid-operation aborts the request. Words already committed stay; uncommitted words are never written.

Handshake:
- A request is accepted at the rising edge where REQ_VALID & REQ_READY.
- Call that cycle 0.
- Line address and REQ_WE are latched at acceptance. REQ_WDATA is latched whole at acceptance.
- Inputs are ignored afterwards.
- REQ_READY = (state==IDLE), so REQ_VALID while busy is ignored.
- No backpressure on beats. The initiator must stall, which CacheFSM already does.

State machine: IDLE, WAIT, READ_BURST, WRITE_BURST.
- IDLE: accept with REQ_WE=0 goes to WAIT (or straight to READ_BURST if LATENCY==1). Accept with REQ_WE=1 goes to WAIT or WRITE_BURST in the same way.
- WAIT: down-counter loaded with LATENCY-1 at accept. At 0, moves to the burst state; beat counter cleared.
- READ_BURST:
  - Beat i is visible in cycle LATENCY+i with RESP_VALID=1, RESP_IDX=i, RESP_DATA=mem[line*W+i].
  - RESP_LAST=1 only in cycle LATENCY+W-1; then return to IDLE.
  - RESP_DATA is 0 whenever RESP_VALID=0.
- WRITE_BURST:
  - REQ_WDATA[i] is committed at the end of cycle LATENCY+i.
  - WR_DONE=1 only in cycle LATENCY+W-1; then return to IDLE.
- BUSY = !IDLE.
- REQ_READY is high again in cycle LATENCY+W, so back-to-back requests take W+LATENCY cycles each.
- A read accepted in cycle LATENCY+W observes the full preceding writeback (no hazard).

Address rules:
- line = REQ_ADDR[31 : log2(W)+2]. Beats always run idx 0..W-1 regardless of the low bits.
- Out of range (line*W ≥ DEPTH, e.g. ≥0x10000 for defaults, the MMIO region):
  - read beats carry 0;
  - writes are dropped;
  - handshake and timing are identical to in-range requests.

Decomposition:
- Package otter_mem_pkg:
  - LINE_WORDS=4 constant;
  - line_t typedef (logic [31:0] [LINE_WORDS]);
  - mem_resp_state_t enum (IDLE, WAIT, READ_BURST, WRITE_BURST).
- Sub-module line_mem_array: single-port DEPTH x 32 word RAM with synchronous write and synchronous read-enable, BRAM-inferable.
- line_mem_responder owns the FSM, counters, range check, and request latches.

Test Plan:
- Preload mem[0x40..0x43] = 0x11,0x22,0x33,0x44; read REQ_ADDR=0x100 accepted cycle 0 -> RESP_VALID cycles 4–7, RESP_IDX 0..3, data 0x11..0x44, RESP_LAST only cycle 7, REQ_READY=1 cycle 8.
- Write 0x200 with {0xA0,0xA1,0xA2,0xA3}, then read 0x200 accepted cycle 8 -> WR_DONE only cycle 7; read beats cycles 12–15 = 0xA0..0xA3.
- Read 0x20C (misaligned) -> identical beats to a 0x200 read, idx order 0..3.
- Write 0x10000 with 0xDEADBEEF×4, then read 0x10000 -> WR_DONE cycle 7; read beats all 0; line 0 unchanged.
- REQ_VALID held high cycles 1–7 with REQ_ADDR changing each cycle -> REQ_READY=0 cycles 1–7, first request's data streamed; second request accepted cycle 8 with the address present then.
- Writeback of {1,2,3,4} to 0x300 over old {0,0,0,0}, RST pulsed mid-cycle 5 -> all outputs 0 and REQ_READY=1 immediately; no WR_DONE; later read of 0x300 returns {1,0,0,0}.
